// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit ALU: queues commands, issues them, returns results.
// Define ALU_SEQ_ERRCNT_EN to add the err_count output and err_clr input.
module alu_cmd_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   input  logic        cmd_sub,
   output logic [3:0]  alu_op,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [15:0] alu_mode,
   input  logic [15:0] alu_result,
   input  logic        alu_err,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic [3:0]  rsp_op,
   output logic        busy
`ifdef ALU_SEQ_ERRCNT_EN
   ,
   output logic [15:0] err_count,
   input  logic        err_clr
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(ALU_LAT + 2);
   localparam logic [3:0] OP_NOP = 4'd11;
   localparam logic [3:0] OP_BAD = 4'd14;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        sub;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   cmd_t          mem [DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop, take, sample;
   logic [LW-1:0] cnt;
   state_t        state, state_n;

   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr];
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{cmd_op, cmd_a, cmd_b, cmd_sub};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   // A take pops the head either from IDLE or on the response handshake edge.
   always_comb begin
      state_n = state;
      take    = 1'b0;
      sample  = 1'b0;
      unique case (state)
         IDLE:  take = !empty;
         ISSUE: state_n = WAIT;
         WAIT: begin
            if (cnt == '0) begin
               sample  = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_n = IDLE;
               take    = !empty;
            end
         end
         default: state_n = IDLE;
      endcase
      if (take) state_n = (head.op == OP_BAD) ? RESP : ISSUE;
      pop = take;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_op   <= OP_NOP;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_mode <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
         rsp_op   <= '0;
         cnt      <= '0;
      end else begin
         if (take) begin
            if (head.op == OP_BAD) begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
               rsp_op   <= OP_BAD;
            end else begin
               alu_op   <= head.op;
               alu_a    <= head.a;
               alu_b    <= head.b;
               alu_mode <= (head.op == 4'd8 && head.sub) ? 16'hFFFF : 16'h0000;
            end
         end
         if (state == ISSUE) cnt <= LW'(ALU_LAT);
         if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
         if (sample) begin
            rsp_data <= alu_result;
            rsp_err  <= alu_err && (alu_op inside {4'd8, 4'd9, 4'd10});
            rsp_op   <= alu_op;
            alu_op   <= OP_NOP;
         end
      end
   end

`ifdef ALU_SEQ_ERRCNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    err_count <= '0;
      else if (err_clr)              err_count <= '0;
      else if (rsp_valid && rsp_ready && rsp_err && err_count != 16'hFFFF)
                                     err_count <= err_count + 1'b1;
   end
`endif

endmodule
